serial_alu_sequencer: RTL and testbench
=======================================

# serial_alu_sequencer

Bit-serial N-bit arithmetic engine that drives a 1-bit arithmetic slice one bit per clock, LSB first. It accepts two WIDTH-bit operands and a 2-bit opcode over a valid/ready request port. It serialises the operands into the slice and carries the slice's carry between bits. It then assembles and presents the WIDTH-bit result, final carry and zero flag on a valid/ready result port. It is the operand-issuing, result-collecting end of the 1-bit arithmetic slice interface and is used wherever area matters more than throughput.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  reset; synchronous, active-high
- req_valid_in  input  1  request operands/opcode valid
- req_ready_out  output  1  engine idle and able to accept a request
- a_data_in  input  WIDTH  operand A
- b_data_in  input  WIDTH  operand B (ignored for PASS/INC)
- op_in  input  2  opcode: 00 PASS A, 01 A+B, 10 A−B, 11 A+1
- res_valid_out  output  1  result valid
- res_ready_in  input  1  consumer accepts result
- res_data_out  output  WIDTH  result
- res_carry_out  output  1  final carry (SUB: 1 = no borrow, A≥B)
- res_zero_out  output  1  res_data_out == 0
- busy_out  output  1  high in SHIFT and DONE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: req_ready_out=1. On req_valid_in & req_ready_out at an edge, do the following and go to SHIFT:
  - latch A, B and op;
  - clear the result register;
  - bit counter ← 0;
  - carry register ← 1 for SUB/INC, 0 for PASS/ADD.
- SHIFT: each edge performs one slice evaluation on A[0], b_eff[0], op and carry:
  - b_eff is B for ADD, ~B for SUB, 0 for PASS/INC;
  - INC injects +1 solely via the initial carry;
  - PASS forces the carry register to stay 0.
- SHIFT register updates per edge:
  - A and B shift right;
  - result ← {sum, result[WIDTH-1:1]};
  - carry ← slice carry;
  - counter increments.
- When the counter reaches WIDTH−1 and that edge completes, go to DONE with res_valid_out=1.
- DONE: outputs held stable. On res_valid_out & res_ready_in at an edge, go to IDLE and drop res_valid_out.
- res_zero_out is registered with the final bit.
- Arithmetic is modulo 2^WIDTH. Carry-out is the carry from bit WIDTH−1.
- Only one operation is in flight. Requests are not accepted in SHIFT or DONE.

## Timing
- Reset (rst_in high at an edge): state IDLE. res_valid_out, res_data_out, res_carry_out, res_zero_out and busy_out all become 0.
- req_ready_out is 0 while rst_in is high and 1 in IDLE otherwise. It is combinational from state and rst_in.
- Latency: request accepted at edge E0 gives res_valid_out=1 after edge E0+WIDTH.
- Throughput: at most one result per WIDTH+2 cycles (accept, WIDTH shifts, result handshake, back to IDLE).
- Next request is accepted no earlier than the edge after the result handshake edge. There is no same-cycle IDLE re-accept from DONE.
- Backpressure: res_ready_in low in DONE holds all result outputs unchanged indefinitely.
- Reset mid-SHIFT or in DONE: operation aborted, no result produced, outputs as reset.
- req_valid_in or operand changes outside IDLE: ignored; latched values are used.
- res_ready_in high outside DONE: no effect.

## Structure
- Shared package alu_pkg holds:
  - opcode constants OP_PASS=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_INC=2'b11;
  - the state encoding IDLE/SHIFT/DONE.
- One sub-module, serial_alu_slice: combinational 1-bit full adder with inputs a, b_eff, cin and outputs sum, cout. It is instantiated once.
- Sequencing, operand preconditioning (b_eff, initial carry) and shift registers live in serial_alu_sequencer.

## Test plan
- WIDTH=8, ADD 0x5A+0x3C, res_ready_in=1 → res_valid_out after E0+8, res_data_out=0x96, carry=0, zero=0.
- SUB 0x20−0x10 → 0x10, carry=1. SUB 0x10−0x20 → 0xF0, carry=0 (borrow).
- INC 0xFF (b_data_in=0x55, ignored) → 0x00, carry=1, zero=1. PASS 0xA5 → 0xA5, carry=0.
- Backpressure: ADD 0x01+0x01 with res_ready_in low 5 cycles in DONE → 0x02 held stable, req_ready_out=0 throughout. Release → IDLE next edge, back-to-back request accepted one edge later.
- Reset asserted one edge during SHIFT after 3 bits → no res_valid_out pulse, all outputs 0. req_ready_out=1 in the first cycle rst_in is low. A new SUB 0x00−0x01 then gives 0xFF, carry=0.
- Request toggling/operand changes during SHIFT → result matches the originally latched operands.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and sequencer state encodings for the bit-serial ALU.
package alu_pkg;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_INC  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/serial_alu_slice.sv
// One-bit full adder slice; purely combinational, no latency, no flow control.
module serial_alu_slice (
    input  logic a,
    input  logic b_eff,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b_eff ^ cin;
    assign cout = (a & b_eff) | (cin & (a ^ b_eff));

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial WIDTH-bit ALU driving one slice LSB first; result valid WIDTH edges after accept.
// One operation in flight; result outputs held while res_ready_in is low.
module serial_alu_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic [WIDTH-1:0] a_data_in,
    input  logic [WIDTH-1:0] b_data_in,
    input  logic [1:0]       op_in,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [WIDTH-1:0] res_data_out,
    output logic             res_carry_out,
    output logic             res_zero_out,
    output logic             busy_out
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic [1:0]       op_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             b_eff;
    logic             sum;
    logic             cout;

    // SUB is A + ~B + 1; the +1 comes from the initial carry, as does INC's.
    always_comb begin
        b_eff = 1'b0;
        case (op_q)
            OP_ADD:  b_eff = b_sh[0];
            OP_SUB:  b_eff = ~b_sh[0];
            default: b_eff = 1'b0;
        endcase
    end

    serial_alu_slice u_slice (
        .a     (a_sh[0]),
        .b_eff (b_eff),
        .cin   (carry_q),
        .sum   (sum),
        .cout  (cout)
    );

    assign res_next      = {sum, res_q[WIDTH-1:1]};
    assign req_ready_out = (state == IDLE) && !rst_in;
    assign busy_out      = (state != IDLE);
    assign res_data_out  = res_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            a_sh          <= '0;
            b_sh          <= '0;
            res_q         <= '0;
            op_q          <= OP_PASS;
            carry_q       <= 1'b0;
            cnt           <= '0;
            res_valid_out <= 1'b0;
            res_carry_out <= 1'b0;
            res_zero_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_in) begin
                        a_sh    <= a_data_in;
                        b_sh    <= b_data_in;
                        op_q    <= op_in;
                        res_q   <= '0;
                        cnt     <= '0;
                        carry_q <= (op_in == OP_SUB) || (op_in == OP_INC);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    res_q   <= res_next;
                    carry_q <= (op_q == OP_PASS) ? 1'b0 : cout;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state         <= DONE;
                        res_valid_out <= 1'b1;
                        res_carry_out <= cout;
                        res_zero_out  <= (res_next == '0);
                    end
                end
                DONE: begin
                    if (res_ready_in) begin
                        res_valid_out <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_alu_sequencer.sv
// Directed bench for serial_alu_sequencer with a transaction-level reference model.
module tb_serial_alu_sequencer;
    import alu_pkg::*;

    localparam int          W   = 8;
    localparam int unsigned MOD = 1 << W;

    logic         clk_in       = 1'b0;
    logic         rst_in       = 1'b1;
    logic         req_valid_in = 1'b0;
    logic         req_ready_out;
    logic [W-1:0] a_data_in    = '0;
    logic [W-1:0] b_data_in    = '0;
    logic [1:0]   op_in        = OP_PASS;
    logic         res_valid_out;
    logic         res_ready_in = 1'b1;
    logic [W-1:0] res_data_out;
    logic         res_carry_out;
    logic         res_zero_out;
    logic         busy_out;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .req_valid_in  (req_valid_in),
        .req_ready_out (req_ready_out),
        .a_data_in     (a_data_in),
        .b_data_in     (b_data_in),
        .op_in         (op_in),
        .res_valid_out (res_valid_out),
        .res_ready_in  (res_ready_in),
        .res_data_out  (res_data_out),
        .res_carry_out (res_carry_out),
        .res_zero_out  (res_zero_out),
        .busy_out      (busy_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns {zero, carry, data} from plain integer arithmetic.
    function automatic logic [W+1:0] golden(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        int unsigned r;
        logic        c;
        case (op)
            OP_PASS: begin r = 32'(a);                    c = 1'b0;        end
            OP_ADD:  begin r = 32'(a) + 32'(b);           c = (r >= MOD);  end
            OP_SUB:  begin r = 32'(a) + MOD - 32'(b);     c = (a >= b);    end
            default: begin r = 32'(a) + 1;                c = (r >= MOD);  end
        endcase
        r = r % MOD;
        return {(r == 0), c, r[W-1:0]};
    endfunction

    // Reference model: one job at a time, result appears W edges after acceptance.
    logic         m_idle  = 1'b1;
    logic         m_valid = 1'b0;
    logic         m_known = 1'b1;
    int           m_left  = 0;
    logic [W+1:0] m_pend  = '0;
    logic [W+1:0] m_res   = '0;

    always @(posedge clk_in) begin
        if (rst_in) begin
            m_idle = 1'b1; m_valid = 1'b0; m_known = 1'b1; m_left = 0; m_res = '0;
        end else if (m_idle) begin
            if (req_valid_in) begin
                m_pend  = golden(op_in, a_data_in, b_data_in);
                m_idle  = 1'b0;
                m_known = 1'b0;
                m_left  = W;
            end
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_valid = 1'b1;
                m_known = 1'b1;
                m_res   = m_pend;
            end
        end else if (m_valid && res_ready_in) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    always @(posedge clk_in) begin
        #1;
        chk("cmp_ready", 32'(req_ready_out), 32'(m_idle && !rst_in));
        chk("cmp_busy",  32'(busy_out),      32'(!m_idle));
        chk("cmp_valid", 32'(res_valid_out), 32'(m_valid));
        if (m_known) begin
            chk("cmp_data",  32'(res_data_out),  32'(m_res[W-1:0]));
            chk("cmp_carry", 32'(res_carry_out), 32'(m_res[W]));
            chk("cmp_zero",  32'(res_zero_out),  32'(m_res[W+1]));
        end
    end

    task automatic do_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ed, input logic ec,
                         input logic ez, input int hold);
        int n;
        int lat;
        n = 0;
        while (!req_ready_out && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        chk({nm, "_ready"}, 32'(req_ready_out), 32'd1);
        res_ready_in = (hold == 0);
        req_valid_in = 1'b1;
        a_data_in    = a;
        b_data_in    = b;
        op_in        = op;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        chk({nm, "_accept"}, 32'(busy_out), 32'd1);
        // Scramble the request port while the job runs; latched operands must win.
        lat = 0;
        while (!res_valid_out && lat < 40) begin
            req_valid_in = 1'($urandom_range(0, 1));
            a_data_in    = W'($urandom);
            b_data_in    = W'($urandom);
            op_in        = 2'($urandom_range(0, 3));
            @(negedge clk_in);
            lat++;
        end
        req_valid_in = 1'b0;
        chk({nm, "_latency"}, 32'(lat), 32'(W));
        chk({nm, "_data"},    32'(res_data_out),  32'(ed));
        chk({nm, "_carry"},   32'(res_carry_out), 32'(ec));
        chk({nm, "_zero"},    32'(res_zero_out),  32'(ez));
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk_in);
                chk({nm, "_hold_valid"}, 32'(res_valid_out), 32'd1);
                chk({nm, "_hold_data"},  32'(res_data_out),  32'(ed));
                chk({nm, "_hold_ready"}, 32'(req_ready_out), 32'd0);
            end
            res_ready_in = 1'b1;
            @(negedge clk_in);
            chk({nm, "_rel_valid"}, 32'(res_valid_out), 32'd0);
            chk({nm, "_rel_ready"}, 32'(req_ready_out), 32'd1);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk_in);
        chk("rst_valid", 32'(res_valid_out), 32'd0);
        chk("rst_data",  32'(res_data_out),  32'd0);
        chk("rst_carry", 32'(res_carry_out), 32'd0);
        chk("rst_zero",  32'(res_zero_out),  32'd0);
        chk("rst_busy",  32'(busy_out),      32'd0);
        chk("rst_ready", 32'(req_ready_out), 32'd0);
        rst_in = 1'b0;
        #1;
        chk("rst_ready_low", 32'(req_ready_out), 32'd1);
        @(negedge clk_in);

        do_op("add",   OP_ADD,  8'h5A, 8'h3C, 8'h96, 1'b0, 1'b0, 0);
        do_op("sub_a", OP_SUB,  8'h20, 8'h10, 8'h10, 1'b1, 1'b0, 0);
        do_op("sub_b", OP_SUB,  8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 0);
        do_op("inc",   OP_INC,  8'hFF, 8'h55, 8'h00, 1'b1, 1'b1, 0);
        do_op("pass",  OP_PASS, 8'hA5, 8'hFF, 8'hA5, 1'b0, 1'b0, 0);
        do_op("bp",    OP_ADD,  8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 5);
        do_op("b2b",   OP_ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 0);
        do_op("sub_z", OP_SUB,  8'h5A, 8'h5A, 8'h00, 1'b1, 1'b1, 0);

        // Abort a job after three bits have been shifted.
        while (!req_ready_out) @(negedge clk_in);
        req_valid_in = 1'b1;
        a_data_in    = 8'h33;
        b_data_in    = 8'h44;
        op_in        = OP_ADD;
        @(negedge clk_in);
        req_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready_out), 32'd1);
        chk("abort_valid", 32'(res_valid_out), 32'd0);
        chk("abort_data",  32'(res_data_out),  32'd0);
        chk("abort_carry", 32'(res_carry_out), 32'd0);
        chk("abort_zero",  32'(res_zero_out),  32'd0);
        chk("abort_busy",  32'(busy_out),      32'd0);
        repeat (W + 2) begin
            @(negedge clk_in);
            chk("abort_no_result", 32'(res_valid_out), 32'd0);
        end
        do_op("sub_post", OP_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 0);

        repeat (3) @(negedge clk_in);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

endmodule
